melody_player: RTL and testbench

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/music_pkg.sv | 15 +
 rtl/melody_rom.sv | 39 +++
 rtl/melody_player.sv | 137 +++++++++++++
 tb/tb_melody_player.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared note-code constants and FSM state encoding for the melody player
// and the blocks that consume its note codes.
package music_pkg;

  localparam logic [7:0] NOTE_REST = 8'd0;
  localparam logic [7:0] NOTE_MAX  = 8'd29;
  localparam logic [7:0] NOTE_END  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/melody_rom.sv
// Combinational song ROM: four songs of up to 64 entries, addressed by
// {song, addr}; NOTE_END terminates a song.
module melody_rom
  import music_pkg::*;
(
  input  logic [1:0] song,
  input  logic [5:0] addr,
  output logic [7:0] data
);

  // Song 2 exercises pass-through codes and a mid-song rest; song 3 has
  // no end marker, so it only ends on the last address.
  always_comb begin
    data = NOTE_END;
    case (song)
      2'd0: begin
        case (addr)
          6'd0:    data = 8'd1;
          6'd1:    data = 8'd1;
          6'd2:    data = 8'd5;
          default: data = NOTE_END;
        endcase
      end
      2'd1: data = NOTE_END;
      2'd2: begin
        case (addr)
          6'd0:    data = 8'd12;
          6'd1:    data = 8'd30;
          6'd2:    data = 8'd254;
          6'd3:    data = NOTE_REST;
          default: data = NOTE_END;
        endcase
      end
      2'd3: data = 8'd3 + {5'd0, addr[2:0]};
      default: data = NOTE_END;
    endcase
  end

endmodule

// File: rtl/melody_player.sv
// Steps through a ROM song one beat per entry, splitting each beat into a
// held note and a short silent gap, with optional looping.
module melody_player
  import music_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BEAT_HZ  = 8,
  parameter int SONG_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] song_sel,
  output logic [7:0] note_idx,
  output logic       playing,
  output logic       done
);

  localparam int BEAT_TICKS = CLK_HZ / BEAT_HZ;
  localparam int GAP_TICKS  = BEAT_TICKS / 8;
  localparam int NOTE_TICKS = BEAT_TICKS - GAP_TICKS;
  localparam int TICK_W     = $clog2(BEAT_TICKS + 1);

  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [5:0]        LAST_ADDR = 6'(SONG_LEN - 1);

  if (BEAT_TICKS < 8) begin : g_bad_beat
    $error("melody_player: CLK_HZ/BEAT_HZ must be at least 8");
  end
  if (SONG_LEN < 1 || SONG_LEN > 64 || (SONG_LEN & (SONG_LEN - 1)) != 0) begin : g_bad_len
    $error("melody_player: SONG_LEN must be a power of two no larger than 64");
  end

  state_t              state;
  logic [5:0]          addr;
  logic [TICK_W-1:0]   tick;
  logic [1:0]          song;
  logic                end_next;
  logic [1:0]          rom_song;
  logic [5:0]          rom_addr;
  logic [7:0]          rom_data;

  // One ROM port serves everything: during NOTE it peeks at the next entry
  // so the end decision is ready in GAP, where it then fetches the next note.
  always_comb begin
    rom_song = song;
    rom_addr = addr + 6'd1;
    if (start) begin
      rom_song = song_sel;
      rom_addr = '0;
    end else if (state == GAP && end_next) begin
      rom_addr = '0;
    end
  end

  melody_rom u_rom (
    .song (rom_song),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      tick     <= '0;
      song     <= '0;
      end_next <= 1'b0;
      note_idx <= NOTE_REST;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        addr     <= '0;
        tick     <= '0;
        note_idx <= NOTE_REST;
        playing  <= 1'b0;
      end else if (start) begin
        song     <= song_sel;
        addr     <= '0;
        tick     <= '0;
        end_next <= 1'b0;
        if (rom_data == NOTE_END) begin
          state    <= IDLE;
          note_idx <= NOTE_REST;
          playing  <= 1'b0;
          done     <= 1'b1;
        end else begin
          state    <= NOTE;
          note_idx <= rom_data;
          playing  <= 1'b1;
        end
      end else begin
        case (state)
          NOTE: begin
            if (tick == NOTE_LAST) begin
              state    <= GAP;
              tick     <= '0;
              note_idx <= NOTE_REST;
              end_next <= (addr == LAST_ADDR) || (rom_data == NOTE_END);
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          GAP: begin
            if (tick == GAP_LAST) begin
              tick <= '0;
              if (end_next && !loop_en) begin
                state   <= IDLE;
                addr    <= '0;
                playing <= 1'b0;
                done    <= 1'b1;
              end else begin
                state    <= NOTE;
                addr     <= end_next ? 6'd0 : addr + 6'd1;
                note_idx <= rom_data;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          default: begin
            state    <= IDLE;
            note_idx <= NOTE_REST;
            playing  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player at 8 ticks per beat (7 note + 1 gap):
// vector table for the songs and controls, hand sequences for reset and song length.
module tb_melody_player;
  import music_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [7:0] note_idx;
  logic       playing;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [1:0] sel;
    logic [7:0] note;
    logic       play;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  melody_player #(.CLK_HZ(80), .BEAT_HZ(10), .SONG_LEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .song_sel (song_sel),
    .note_idx (note_idx),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic addv(input logic s, input logic p, input logic l, input logic [1:0] sel,
                      input logic [7:0] n, input logic pl, input logic d);
    vec_t v;
    v.start = s; v.stop = p; v.loop_en = l; v.sel = sel;
    v.note = n; v.play = pl; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic addn(input int count, input logic l, input logic [1:0] sel,
                      input logic [7:0] n, input logic pl);
    repeat (count) addv(1'b0, 1'b0, l, sel, n, pl, 1'b0);
  endtask

  // A full beat: seven cycles of the note, then one silent gap cycle.
  task automatic addBeat(input logic l, input logic [1:0] sel, input logic [7:0] n);
    addn(7, l, sel, n, 1'b1);
    addn(1, l, sel, NOTE_REST, 1'b1);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic l, input logic [1:0] sel);
    @(negedge clk);
    start = s; stop = p; loop_en = l; song_sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] n, input logic pl, input logic d);
    checks++;
    if (note_idx !== n || playing !== pl || done !== d) begin
      errors++;
      $display("[TB] FAIL %s: got note=%0d playing=%0b done=%0b, expected note=%0d playing=%0b done=%0b",
               name, note_idx, playing, done, n, pl, d);
    end
  endtask

  initial begin
    // Song 0 {1,1,5}; song_sel wiggles after start and must be ignored.
    addv(1, 0, 0, 2'd0, 8'd1, 1, 0);
    addn(6, 0, 2'd3, 8'd1, 1);
    addn(1, 0, 2'd3, NOTE_REST, 1);
    addBeat(0, 2'd2, 8'd1);
    addBeat(0, 2'd1, 8'd5);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 1);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 0);
    // Song 2: pass-through codes 30 and 254 plus a mid-song rest.
    addv(1, 0, 0, 2'd2, 8'd12, 1, 0);
    addn(6, 0, 2'd1, 8'd12, 1);
    addn(1, 0, 2'd1, NOTE_REST, 1);
    addBeat(0, 2'd1, 8'd30);
    addBeat(0, 2'd1, 8'd254);
    addBeat(0, 2'd1, NOTE_REST);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 1);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 0);
    // Song 0 looping three times, then loop_en drops before the fourth end.
    addv(1, 0, 1, 2'd0, 8'd1, 1, 0);
    addn(6, 1, 2'd0, 8'd1, 1);
    addn(1, 1, 2'd0, NOTE_REST, 1);
    addBeat(1, 2'd0, 8'd1);
    addBeat(1, 2'd0, 8'd5);
    for (int k = 0; k < 2; k++) begin
      addBeat(1, 2'd0, 8'd1);
      addBeat(1, 2'd0, 8'd1);
      addBeat(1, 2'd0, 8'd5);
    end
    addBeat(1, 2'd0, 8'd1);
    addBeat(0, 2'd0, 8'd1);
    addBeat(0, 2'd0, 8'd5);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 1);
    addv(0, 0, 0, 2'd0, NOTE_REST, 0, 0);
    // Stop during the second note.
    addv(1, 0, 0, 2'd0, 8'd1, 1, 0);
    addn(6, 0, 2'd0, 8'd1, 1);
    addn(1, 0, 2'd0, NOTE_REST, 1);
    addn(3, 0, 2'd0, 8'd1, 1);
    addv(0, 1, 0, 2'd0, NOTE_REST, 0, 0);
    addn(3, 0, 2'd0, NOTE_REST, 0);
    // Start and stop together while idle, then while playing.
    addv(1, 1, 0, 2'd0, NOTE_REST, 0, 0);
    addn(2, 0, 2'd0, NOTE_REST, 0);
    addv(1, 0, 0, 2'd2, 8'd12, 1, 0);
    addn(2, 0, 2'd0, 8'd12, 1);
    addv(1, 1, 0, 2'd0, NOTE_REST, 0, 0);
    addn(2, 0, 2'd0, NOTE_REST, 0);
    // Restart mid-song with a different song.
    addv(1, 0, 0, 2'd0, 8'd1, 1, 0);
    addn(6, 0, 2'd0, 8'd1, 1);
    addn(1, 0, 2'd0, NOTE_REST, 1);
    addn(2, 0, 2'd0, 8'd1, 1);
    addv(1, 0, 0, 2'd2, 8'd12, 1, 0);
    addn(3, 0, 2'd0, 8'd12, 1);
    addv(0, 1, 0, 2'd0, NOTE_REST, 0, 0);
    addn(1, 0, 2'd0, NOTE_REST, 0);
    // Song 1 is empty: no playback, done one edge after start.
    addv(1, 0, 0, 2'd1, NOTE_REST, 0, 1);
    addn(2, 0, 2'd0, NOTE_REST, 0);

    #1;
    checkOutput("reset_state", NOTE_REST, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", NOTE_REST, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 2'd0);
    checkOutput("idle_after_reset", NOTE_REST, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].loop_en, vecs[i].sel);
      checkOutput($sformatf("vec%0d", i), vecs[i].note, vecs[i].play, vecs[i].done);
    end

    // Song 3 has no end marker: 64 beats, ending on the last address.
    applyStimulus(1, 0, 0, 2'd3);
    for (int i = 0; i < 64; i++) begin
      for (int c = 0; c < 8; c++) begin
        if (!(i == 0 && c == 0)) applyStimulus(0, 0, 0, 2'd0);
        checkOutput($sformatf("song3_b%0d_c%0d", i, c),
                    (c < 7) ? 8'(3 + (i % 8)) : NOTE_REST, 1'b1, 1'b0);
      end
    end
    applyStimulus(0, 0, 0, 2'd0);
    checkOutput("song3_done", NOTE_REST, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 2'd0);
    checkOutput("song3_after", NOTE_REST, 1'b0, 1'b0);

    // Reset dropped between clock edges mid-note.
    applyStimulus(1, 0, 0, 2'd0);
    repeat (3) applyStimulus(0, 0, 0, 2'd0);
    checkOutput("pre_reset_note", 8'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", NOTE_REST, 1'b0, 1'b0);
    repeat (2) applyStimulus(0, 0, 0, 2'd0);
    checkOutput("reset_hold_mid", NOTE_REST, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 2'd2);
      checkOutput($sformatf("post_reset_idle%0d", i), NOTE_REST, 1'b0, 1'b0);
    end
    applyStimulus(1, 0, 0, 2'd0);
    checkOutput("post_reset_start", 8'd1, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 2'd0);
    checkOutput("post_reset_stop", NOTE_REST, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
